// File: rtl/iterative_shifter_nbit.sv
// rtl/iterative_shifter_nbit.sv - multi-cycle SLL/SRL/SRA(/ROR) shifter, STEP positions per clock; optional ROR via ITER_SHIFTER_ROTATE_EN
module iterative_shifter_nbit #(
  parameter int N    = 32,
  parameter int STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] shamt,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         result
);

  localparam int SW = $clog2(N);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [SW-1:0] STEP_V = SW'(STEP);
`ifdef ITER_SHIFTER_ROTATE_EN
  localparam logic [SW:0] N_V = (SW+1)'(N);
`endif

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [SW-1:0] rem_q, rem_d;
  logic [1:0]    op_q, op_d;
  logic [N-1:0]  result_q, result_d;

  logic [SW-1:0] step_k;
  logic [SW-1:0] rem_next;
  logic [N-1:0]  shifted;
  logic          zero_amt;

  // Positions moved this cycle: the full STEP, or whatever remains if less.
  always_comb begin
    step_k   = (rem_q < STEP_V) ? rem_q : STEP_V;
    rem_next = rem_q - step_k;
  end

  // Without the rotate option, op=11 completes immediately with result=a.
`ifdef ITER_SHIFTER_ROTATE_EN
  assign zero_amt = (shamt == '0);
`else
  assign zero_amt = (shamt == '0) || (op == OP_ROR);
`endif

  // One iteration of the shift on the accumulator using the latched op.
  always_comb begin
    shifted = acc_q;
    case (op_q)
      OP_SLL:  shifted = acc_q << step_k;
      OP_SRL:  shifted = acc_q >> step_k;
      OP_SRA:  shifted = $signed(acc_q) >>> step_k;
      default: begin
`ifdef ITER_SHIFTER_ROTATE_EN
        // step_k is never 0 in SHIFT, so N-step_k stays below N.
        shifted = (acc_q >> step_k) | (acc_q << (N_V - {1'b0, step_k}));
`else
        shifted = acc_q;
`endif
      end
    endcase
  end

  // FSM next-state: accept in IDLE, iterate in SHIFT, one-cycle DONE pulse.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = a;
          op_d  = op;
          if (zero_amt) begin
            rem_d    = '0;
            result_d = a;
            state_d  = ST_DONE;
          end else begin
            rem_d   = shamt;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = shifted;
        rem_d = rem_next;
        if (rem_next == '0) begin
          result_d = shifted;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight operation at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_iterative_shifter_nbit.sv
// tb/tb_iterative_shifter_nbit.sv - directed self-checking bench for iterative_shifter_nbit (STEP=1 and STEP=4)
module tb_iterative_shifter_nbit;

  logic        clk;
  logic        rst;
  logic        start1, start4;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;

  int tests = 0;
  int fails = 0;

  iterative_shifter_nbit #(.N(32), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .a(a), .shamt(shamt),
    .busy(busy1), .done(done1), .result(result1)
  );

  iterative_shifter_nbit #(.N(32), .STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op), .a(a), .shamt(shamt),
    .busy(busy4), .done(done4), .result(result4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input bit w4, input logic [1:0] o, input logic [31:0] av,
                        input logic [4:0] sa, input logic [31:0] exp_res,
                        input int exp_m, input string tag);
    int lat;
    int busy_cnt;
    logic d, b;
    @(negedge clk);
    a = av; shamt = sa; op = o;
    if (w4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    a = $urandom; shamt = 5'($urandom); op = 2'($urandom);
    lat = 0; busy_cnt = 0;
    while (lat < 100) begin
      d = w4 ? done4 : done1;
      b = w4 ? busy4 : busy1;
      if (b) busy_cnt++;
      if (d) break;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_m));
    chk({tag, "_result"}, w4 ? result4 : result1, exp_res);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_m + 1));
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, {30'd0, (w4 ? busy4 : busy1), (w4 ? done4 : done1)}, 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [31:0] res_before;
    rst = 1'b0; start1 = 1'b0; start4 = 1'b0; op = 2'b00; a = '0; shamt = '0;
    #2;
    chk("reset_dut1", {busy1, done1, 30'd0} | result1, 32'd0);
    chk("reset_dut4", {busy4, done4, 30'd0} | result4, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // 1: STEP=1 SLL by 31
    run_op(1'b0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 31, "sll1_31");
    // 2: STEP=4 SRA by 5 (4+1)
    run_op(1'b1, 2'b10, 32'h8000_00F0, 5'd5, 32'hFC00_0007, 2, "sra4_5");
    // 3: SRL by 0
    run_op(1'b0, 2'b01, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 0, "srl1_0");
    run_op(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 0, "srl4_0");
    // extra patterns
    run_op(1'b0, 2'b10, 32'h4000_0000, 5'd3, 32'h0800_0000, 3, "sra1_pos");
    run_op(1'b1, 2'b10, 32'h8000_0000, 5'd16, 32'hFFFF_8000, 4, "sra4_16");
    run_op(1'b1, 2'b01, 32'h8000_0000, 5'd7, 32'h0100_0000, 2, "srl4_7");
    run_op(1'b1, 2'b00, 32'h1234_567F, 5'd31, 32'h8000_0000, 8, "sll4_31");

    // 4: start during SHIFT is ignored
    @(negedge clk);
    a = 32'hF000_0000; shamt = 5'd4; op = 2'b01; start1 = 1'b1;
    @(posedge clk); #1;
    a = 32'h0000_0001; shamt = 5'd1; op = 2'b00;
    lat = -1; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done1) begin
        pulses++;
        if (lat < 0) lat = i;
      end
      if (i == 2) start1 = 1'b0;
      @(posedge clk); #1;
    end
    chk("ignore_latency", 32'(lat), 32'd4);
    chk("ignore_pulses", 32'(pulses), 32'd1);
    chk("ignore_result", result1, 32'h0F00_0000);

    // 5: async reset mid-SHIFT
    @(negedge clk);
    a = 32'h0000_00FF; shamt = 5'd20; op = 2'b00; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #3;
    res_before = result1;
    rst = 1'b0;
    #1;
    chk("rst_result_prior_nonzero", {31'd0, res_before != 32'd0}, 32'd1);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_result", result1, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done1 || busy1) pulses++;
    end
    chk("rst_no_spurious", 32'(pulses), 32'd0);
    run_op(1'b0, 2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C, 2, "sll1_after_rst");

    // 6: op=11
`ifdef ITER_SHIFTER_ROTATE_EN
    run_op(1'b0, 2'b11, 32'h0000_0001, 5'd1, 32'h8000_0000, 1, "op11_dut1");
    run_op(1'b1, 2'b11, 32'h0000_00AB, 5'd8, 32'hAB00_0000, 2, "op11_dut4");
`else
    run_op(1'b0, 2'b11, 32'h0000_0001, 5'd1, 32'h0000_0001, 0, "op11_dut1");
    run_op(1'b1, 2'b11, 32'h0000_00AB, 5'd8, 32'h0000_00AB, 0, "op11_dut4");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
